// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer
// Runs the row-clear phase after a piece locks. It scans the board for full
// rows and flashes them for FLASH_CYCLES clocks. It then collapses the
// surviving rows toward the bottom, blanks the top rows and returns the new
// board with the line count and score increment.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  S_IDLE     | waiting for i_start; previous results held on outputs
//  S_SCAN     | one row per cycle, bottom to top, building the full-row mask
//  S_FLASH    | full rows shown on o_flash while the down-counter runs out
//  S_COLLAPSE | one row per cycle, copying surviving rows down in place
//  S_FILL     | top rows (one per cleared line) forced empty
//  S_DONE     | one-cycle done/board_we pulse with results valid
module line_clear_sequencer #(
    parameter int ROWS         = 20,
    parameter int COLS         = 12,
    parameter int FLASH_CYCLES = 50_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [ROWS*COLS-1:0] i_board_in,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_board_we,
    output logic [ROWS*COLS-1:0] o_board_out,
    output logic [ROWS*COLS-1:0] o_flash,
    output logic [4:0]           o_lines_cleared,
    output logic [6:0]           o_score_add
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(FLASH_CYCLES + 1);
    localparam int N  = ROWS * COLS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FLASH,
        S_COLLAPSE,
        S_FILL,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_work;
    logic [ROWS-1:0] r_mask;
    logic [RW-1:0]   r_ptr;
    logic [RW-1:0]   r_wr;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_board_out;
    logic [N-1:0]    r_flash;
    logic [4:0]      r_lines;
    logic [6:0]      r_score;

    logic [COLS-1:0] w_row_rd;
    logic            w_row_full;
    logic [ROWS-1:0] w_mask_scan;
    logic [N-1:0]    w_flash_exp;
    logic [4:0]      w_popcount;
    logic [N-1:0]    w_filled;

    // Classic line scoring; five or more lines only happens with a hand-built board.
    function automatic logic [6:0] score_of(input logic [4:0] n);
        case (n)
            5'd0:    score_of = 7'd0;
            5'd1:    score_of = 7'd1;
            5'd2:    score_of = 7'd3;
            5'd3:    score_of = 7'd5;
            5'd4:    score_of = 7'd8;
            default: score_of = {1'b0, n, 1'b0};
        endcase
    endfunction

    // The row under the shared scan/read pointer, and whether it is full.
    always_comb begin
        w_row_rd   = r_work[int'(r_ptr)*COLS +: COLS];
        w_row_full = &w_row_rd;
    end

    // Mask including the row being scanned this cycle, and its per-cell expansion for the flash output.
    always_comb begin
        w_mask_scan        = r_mask;
        w_mask_scan[r_ptr] = r_mask[r_ptr] | w_row_full;
        w_flash_exp        = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_flash_exp[r*COLS +: COLS] = {COLS{w_mask_scan[r]}};
        end
    end

    // Number of full rows, then the collapsed board with the vacated top rows emptied.
    always_comb begin
        w_popcount = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_popcount = w_popcount + {4'b0, r_mask[r]};
        end
        w_filled = r_work;
        for (int r = 0; r < ROWS; r++) begin
            if (r < int'(w_popcount)) begin
                w_filled[r*COLS +: COLS] = '0;
            end
        end
    end

    // Sequencer: state, working board, and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_mask      <= '0;
            r_ptr       <= '0;
            r_wr        <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_board_out <= '0;
            r_flash     <= '0;
            r_lines     <= '0;
            r_score     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_work  <= i_board_in;
                        r_mask  <= '0;
                        r_ptr   <= RW'(ROWS - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_mask <= w_mask_scan;
                    if (r_ptr == '0) begin
                        if (w_mask_scan == '0) begin
                            r_board_out <= r_work;
                            r_lines     <= '0;
                            r_score     <= '0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_flash <= w_flash_exp;
                            r_cnt   <= CW'(FLASH_CYCLES);
                            r_state <= S_FLASH;
                        end
                    end else begin
                        r_ptr <= r_ptr - 1'b1;
                    end
                end
                S_FLASH: begin
                    if (r_cnt == CW'(1)) begin
                        r_flash <= '0;
                        r_ptr   <= RW'(ROWS - 1);
                        r_wr    <= RW'(ROWS - 1);
                        r_state <= S_COLLAPSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_COLLAPSE: begin
                    // The write pointer never passes the read pointer, so the copy is in place.
                    if (!r_mask[r_ptr]) begin
                        r_work[int'(r_wr)*COLS +: COLS] <= w_row_rd;
                        r_wr <= r_wr - 1'b1;
                    end
                    if (r_ptr == '0) begin
                        r_state <= S_FILL;
                    end else begin
                        r_ptr <= r_ptr - 1'b1;
                    end
                end
                S_FILL: begin
                    r_work      <= w_filled;
                    r_board_out <= w_filled;
                    r_lines     <= w_popcount;
                    r_score     <= score_of(w_popcount);
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_board_we      = r_done;
    assign o_board_out     = r_board_out;
    assign o_flash         = r_flash;
    assign o_lines_cleared = r_lines;
    assign o_score_add     = r_score;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Bench for line_clear_sequencer with a short flash time.
module tb_line_clear_sequencer;

    localparam int ROWS = 20;
    localparam int COLS = 12;
    localparam int FC   = 4;
    localparam int N    = ROWS * COLS;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N-1:0]    board_in;
    logic            busy, done, board_we;
    logic [N-1:0]    board_out, flash;
    logic [4:0]      lines_cleared;
    logic [6:0]      score_add;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]    board;
        logic [N-1:0]    exp_board;
        logic [ROWS-1:0] exp_mask;
        int              exp_lines;
        int              exp_score;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];

    line_clear_sequencer #(.ROWS(ROWS), .COLS(COLS), .FLASH_CYCLES(FC)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_board_in(board_in),
        .o_busy(busy), .o_done(done), .o_board_we(board_we),
        .o_board_out(board_out), .o_flash(flash),
        .o_lines_cleared(lines_cleared), .o_score_add(score_add)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not terminate");
    end

    task automatic chk_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] put_row(input logic [N-1:0] b, input int r, input logic [COLS-1:0] v);
        logic [N-1:0] t;
        t = b;
        t[r*COLS +: COLS] = v;
        return t;
    endfunction

    function automatic logic [N-1:0] expand(input logic [ROWS-1:0] m);
        logic [N-1:0] e;
        e = '0;
        for (int r = 0; r < ROWS; r++) e[r*COLS +: COLS] = {COLS{m[r]}};
        return e;
    endfunction

    function automatic int score_model(input int n);
        case (n)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 5;
            4: return 8;
            default: return 2 * n;
        endcase
    endfunction

    // Reference: keep non-full rows in order, stacked from the bottom.
    function automatic vec_t model(input logic [N-1:0] b);
        vec_t v;
        int w;
        logic [COLS-1:0] row;
        v.board = b; v.exp_board = '0; v.exp_mask = '0; v.exp_lines = 0;
        w = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = b[r*COLS +: COLS];
            if (row == {COLS{1'b1}}) begin
                v.exp_mask[r] = 1'b1;
                v.exp_lines++;
            end else begin
                v.exp_board[w*COLS +: COLS] = row;
                w--;
            end
        end
        v.exp_score = score_model(v.exp_lines);
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk_int({tag, "_busy"}, int'(busy), 0);
        chk_int({tag, "_done"}, int'(done), 0);
        chk_int({tag, "_we"}, int'(board_we), 0);
        chk_vec({tag, "_board_out"}, board_out, '0);
        chk_vec({tag, "_flash"}, flash, '0);
        chk_int({tag, "_lines"}, int'(lines_cleared), 0);
        chk_int({tag, "_score"}, int'(score_add), 0);
    endtask

    // One transaction; optionally fire a second start during the first flash cycle.
    task automatic run(input int idx, input bit inject);
        vec_t v, e;
        int edges, flash_cycles, exp_edges;
        bit seen, flash_bad, busy_bad, injected, clear_inj;
        logic [N-1:0] exp_flash;
        v = vecs[idx];
        exp_flash = expand(v.exp_mask);
        @(posedge clk); #1;
        start = 1'b1; board_in = v.board;
        sb_q.push_back(v);
        @(posedge clk); #1;
        start = 1'b0; board_in = '1;
        edges = 0; seen = 0; flash_cycles = 0; flash_bad = 0; busy_bad = 0;
        injected = 0; clear_inj = 0;
        while (!seen && edges < 200) begin
            if (flash != '0) begin
                flash_cycles++;
                if (flash !== exp_flash) flash_bad = 1;
                if (inject && !injected) begin
                    start = 1'b1; board_in = '1; injected = 1; clear_inj = 1;
                end
            end
            @(posedge clk); #1;
            edges++;
            if (clear_inj) begin start = 1'b0; clear_inj = 0; end
            if (busy !== 1'b1) busy_bad = 1;
            if (done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL vec%0d_timeout: no done after %0d cycles", idx, edges);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        exp_edges = (e.exp_lines == 0) ? ROWS : 2 * ROWS + FC + 1;
        chk_int($sformatf("vec%0d_latency", idx), edges + 1, exp_edges + 1);
        chk_vec($sformatf("vec%0d_board_out", idx), board_out, e.exp_board);
        chk_int($sformatf("vec%0d_lines", idx), int'(lines_cleared), e.exp_lines);
        chk_int($sformatf("vec%0d_score", idx), int'(score_add), e.exp_score);
        chk_int($sformatf("vec%0d_we", idx), int'(board_we), 1);
        chk_int($sformatf("vec%0d_flash_cycles", idx), flash_cycles, (e.exp_lines == 0) ? 0 : FC);
        chk_int($sformatf("vec%0d_flash_pattern_bad", idx), int'(flash_bad), 0);
        chk_int($sformatf("vec%0d_busy_drop", idx), int'(busy_bad), 0);
        if (inject) chk_int($sformatf("vec%0d_injected", idx), int'(injected), 1);
        @(posedge clk); #1;
        chk_int($sformatf("vec%0d_done_after", idx), int'(done), 0);
        chk_int($sformatf("vec%0d_busy_after", idx), int'(busy), 0);
        chk_vec($sformatf("vec%0d_board_held", idx), board_out, e.exp_board);
        chk_int($sformatf("vec%0d_lines_held", idx), int'(lines_cleared), e.exp_lines);
    endtask

    initial begin
        int n_done, n_busy;
        bit got_flash, left_flash;
        logic [N-1:0] b;

        rst = 1'b1; start = 1'b0; board_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Reset wins over a simultaneous start.
        start = 1'b1; board_in = '1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; board_in = '0;
        chk_int("rst_over_start_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk_int("rst_over_start_busy2", int'(busy), 0);

        // Table of vectors.
        vecs[0] = '{board: '0, exp_board: '0, exp_mask: '0, exp_lines: 0, exp_score: 0};

        b = put_row('0, 19, 12'hFFF); b = put_row(b, 18, 12'h00F);
        vecs[1] = '{board: b, exp_board: put_row('0, 19, 12'h00F),
                    exp_mask: 20'h80000, exp_lines: 1, exp_score: 1};

        b = '0;
        for (int r = 16; r < 20; r++) b = put_row(b, r, 12'hFFF);
        b = put_row(b, 15, 12'h801);
        vecs[2] = '{board: b, exp_board: put_row('0, 19, 12'h801),
                    exp_mask: 20'hF0000, exp_lines: 4, exp_score: 8};

        b = put_row('0, 19, 12'hFFF); b = put_row(b, 17, 12'hFFF);
        b = put_row(b, 18, 12'h0AA); b = put_row(b, 16, 12'h055);
        vecs[3] = '{board: b, exp_board: put_row(put_row('0, 19, 12'h0AA), 18, 12'h055),
                    exp_mask: 20'hA0000, exp_lines: 2, exp_score: 3};

        vecs[4] = '{board: '1, exp_board: '0, exp_mask: '1, exp_lines: 20, exp_score: 40};

        b = '0;
        for (int r = 0; r < ROWS; r++) b = put_row(b, r, 12'($urandom_range(0, 12'hFFE)));
        b = put_row(b, 0, 12'hFFF); b = put_row(b, 5, 12'hFFF); b = put_row(b, 10, 12'hFFF);
        vecs[5] = model(b);

        b = '0;
        for (int r = 2; r < ROWS; r++) b = put_row(b, r, 12'($urandom_range(1, 12'hFFE)));
        foreach (vecs[0].exp_board[i]) begin end
        b = put_row(b, 3, 12'hFFF); b = put_row(b, 4, 12'hFFF); b = put_row(b, 7, 12'hFFF);
        b = put_row(b, 8, 12'hFFF); b = put_row(b, 9, 12'hFFF);
        vecs[6] = model(b);

        for (int i = 0; i < 7; i++) run(i, 1'b0);

        // Second start during FLASH is ignored: exactly one done.
        run(1, 1'b1);
        n_done = 0; n_busy = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        chk_int("inject_extra_done", n_done, 0);
        chk_int("inject_extra_busy", n_busy, 0);

        // Reset in the middle of COLLAPSE aborts without done.
        @(posedge clk); #1;
        start = 1'b1; board_in = vecs[2].board;
        @(posedge clk); #1;
        start = 1'b0;
        got_flash = 0; left_flash = 0;
        for (int k = 0; k < 100 && !left_flash; k++) begin
            @(posedge clk); #1;
            if (flash != '0) got_flash = 1;
            else if (got_flash) left_flash = 1;
        end
        chk_int("abort_reached_collapse", int'(left_flash), 1);
        repeat (3) @(posedge clk);
        #1;
        chk_int("abort_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        rst = 1'b0;
        n_done = 0; n_busy = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        chk_int("abort_no_done", n_done, 0);
        chk_int("abort_idle_busy", n_busy, 0);

        // Normal operation resumes after the abort.
        run(3, 1'b0);
        chk_int("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
